// File: rtl/data_sram_responder_pkg.sv
// Shared CPU definitions: address type, access size and responder defaults.
// Holds the store byte-enable helper used by data_sram_responder.
package cpu_defs;

  typedef logic [31:0] uint32_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  localparam int OUTSTANDING_DEF = 2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Byte enables for a store; size 3 falls through to a full word.
  function automatic logic [3:0] wen_mask(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (1'b1)
      (sz == BYTE): m = 4'b0001 << a;
      (sz == HALF): m = 4'b0011 << {a[1], 1'b0};
      default:      m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_sram_responder_fifo.sv
// resp_fifo: small synchronous FIFO holding responses in acceptance order.
// Push and pop may coincide, including when the FIFO is full.
module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign dout   = mem_q[rptr_q];
  assign do_pop = pop && !empty;

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Storage is written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)   wptr_q <= inc(wptr_q);
      if (do_pop) rptr_q <= inc(rptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Bridges a req/addr_ok/data_ok data port onto a synchronous SRAM.
// Optional RANDOM_DELAY_EN throttles both handshakes from an LFSR.
module data_sram_responder
  import cpu_defs::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  uint32_t     data_addr,
  input  uint32_t     data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output uint32_t     data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output uint32_t     ram_addr,
  output uint32_t     ram_wdata,
  input  uint32_t     ram_rdata
);

  logic [2:0] cnt_q, cnt_d;
  logic       pend_v_q, pend_wr_q;
  logic       gate_a, gate_d;
  logic       accept, push, f_empty, f_full;
  uint32_t    push_data, head;

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state, free-running every cycle.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign gate_a = lfsr_q[0];
  assign gate_d = lfsr_q[1];
`else
  assign gate_a = 1'b1;
  assign gate_d = 1'b1;
`endif

  assign data_addr_ok = !reset && (cnt_q < 3'(OUTSTANDING)) && gate_a;
  assign accept       = data_req && data_addr_ok;
  assign data_data_ok = !reset && !f_empty && gate_d;
  assign data_rdata   = data_data_ok ? head : '0;

  assign ram_en    = accept;
  assign ram_addr  = {data_addr[31:2], 2'b00};
  assign ram_wdata = data_wdata;
  assign ram_wen   = (accept && data_wr) ?
                     wen_mask(data_size, data_addr[1:0]) : 4'b0000;

  assign push      = pend_v_q && !reset;
  assign push_data = pend_wr_q ? '0 : ram_rdata;

  // Outstanding count: accepted requests not yet answered.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !data_data_ok)      cnt_d = cnt_q + 3'd1;
    else if (!accept && data_data_ok) cnt_d = cnt_q - 3'd1;
  end

  // Counter and one-deep pending slot waiting for RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_v_q  <= accept;
      pend_wr_q <= data_wr;
    end
  end

  resp_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (data_data_ok),
    .din   (push_data),
    .dout  (head),
    .empty (f_empty),
    .full  (f_full)
  );

  logic unused_full;
  assign unused_full = f_full;

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, max accepted-but-unanswered requests (legal 1..4).
REQ-002 SHALL have port clk  input  1  the only clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_req  input  1  master request valid.
REQ-005 SHALL have port data_wr  input  1  1=store, 0=load.
REQ-006 SHALL have port data_size  input  2  0=byte, 1=half, 2=word, 3=treated as word.
REQ-007 SHALL have port data_addr  input  32  byte address (uint32_t).
REQ-008 SHALL have port data_wdata  input  32  store data, lane-aligned by master.
REQ-009 SHALL have port data_addr_ok  output  1  request accepted this cycle when high with data_req.
REQ-010 SHALL have port data_data_ok  output  1  one-cycle pulse per response, in acceptance order.
REQ-011 SHALL have port data_rdata  output  32  load data, valid with data_data_ok; 0 for stores.
REQ-012 SHALL have ports ram_en output 1, ram_wen output 4, ram_addr output 32, ram_wdata output 32 (synchronous RAM side).
REQ-013 SHALL have port ram_rdata  input  32  RAM read data, valid one cycle after ram_en.

Function
REQ-014 SHALL accept a request in the cycle data_req && data_addr_ok, and drive ram_en=1, ram_addr={data_addr[31:2],2'b00}, ram_wdata=data_wdata that same cycle.
REQ-015 SHALL drive ram_wen only on accepted stores: size0 -> 4'b0001<<addr[1:0]; size1 -> 4'b0011<<{addr[1],1'b0}; size2/3 -> 4'b1111; loads drive 4'b0000.
REQ-016 SHALL hold an outstanding counter: +1 on accept, -1 on data_data_ok, unchanged when both occur in one cycle.
REQ-017 SHALL assert data_addr_ok only when counter < OUTSTANDING (no same-cycle bypass from a concurrent data_data_ok).
REQ-018 SHALL register one pending slot {valid, wr} per accept; next cycle push {wr ? 0 : ram_rdata} into the response FIFO.
REQ-019 SHALL drive data_data_ok from FIFO head non-empty (subject to REQ-027) and pop head in that cycle; minimum latency accept->data_data_ok is 2 cycles.
REQ-020 SHALL assume the master always sinks data_data_ok (no back-pressure on responses).
REQ-021 SHALL never drop an accepted request: every accept produces exactly one data_data_ok, even if the master has flushed its pipeline.
REQ-022 SHALL size the FIFO to OUTSTANDING entries; the counter bound guarantees no overflow; push and pop in one cycle on a full FIFO is legal.
REQ-023 SHALL not check alignment; misaligned addresses are the master's responsibility.

Reset
REQ-024 SHALL, on reset, clear counter, pending slot, FIFO and LFSR to seed; outputs data_addr_ok=0, data_data_ok=0, data_rdata=0, ram_en=0, ram_wen=0 during the reset cycle.
REQ-025 SHALL discard requests in flight at reset; no data_data_ok is issued for them afterwards.

Configuration
REQ-026 SHALL support macro RANDOM_DELAY_EN; when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle.
REQ-027 SHALL, with RANDOM_DELAY_EN, additionally gate data_addr_ok with lfsr[0] and data_data_ok with lfsr[1]; without it, neither is gated and no LFSR exists.

Structure
REQ-028 SHALL take uint32_t and a mem_size_t enum (BYTE, HALF, WORD) from the shared cpu_defs package; OUTSTANDING default lives there as a constant.
REQ-029 SHALL instantiate one sub-module resp_fifo (synchronous FIFO, parameterised depth/width, push/pop/empty/full).

Verification
REQ-030 Load word: RAM[0x100]=0xDEADBEEF, req/addr 0x100/size2 at cycle N -> ram_en at N, data_data_ok with data_rdata=0xDEADBEEF at N+2.
REQ-031 Byte store: addr 0x203, size0, wdata 0x55000000 -> ram_wen=4'b1000, ram_addr=0x200; data_data_ok with data_rdata=0.
REQ-032 Back-to-back: 4 loads held asserted, OUTSTANDING=2 -> data_addr_ok pattern keeps counter <=2; four data_data_ok in order with correct data.
REQ-033 Reset mid-flight: accept load at N, reset at N+1 -> no data_data_ok at N+2 or later; data_addr_ok=1 at N+2 if data_req high.
REQ-034 RANDOM_DELAY_EN build, 1000 random loads/stores vs reference memory model -> every accept answered once, in order, data matches, counter never exceeds OUTSTANDING.
